// File: rtl/oc8051_wb_pkg.sv
// Purpose: shared constants and types for the 8051 ALU writeback stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package oc8051_wb_pkg;

    // ALU op codes, same encoding as the ALU define set
    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_DA  = 4'b0101;
    localparam logic [3:0] ALU_NOT = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XCH = 4'b1111;

    // PSW bit positions
    localparam int PSW_CY = 7;
    localparam int PSW_AC = 6;
    localparam int PSW_OV = 2;
    localparam int PSW_P  = 0;

    // flag update selector
    localparam logic [1:0] PSET_NONE = 2'b00;
    localparam logic [1:0] PSET_CY   = 2'b01;
    localparam logic [1:0] PSET_CAO  = 2'b10;
    localparam logic [1:0] PSET_CA   = 2'b11;

    // destination selector
    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_ACC  = 2'b01;
    localparam logic [1:0] WR_RAM  = 2'b10;
    localparam logic [1:0] WR_ACCB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MDWAIT = 2'd1,
        ST_WBHOLD = 2'd2
    } wb_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/oc8051_psw_merge.sv
// Purpose: next-value of PSW[7:1] from current PSW, ALU flag update and SFR write.
// Latency: combinational.
// Backpressure: none.
// Ports: i_psw current [7:1]; i_upd/i_psw_set plain-op flag update; i_md_commit
//        MUL/DIV commit (CY cleared, OV loaded); i_cy/i_ac/i_ov ALU flags;
//        i_sfr_wr/i_sfr_data direct PSW write; o_psw next [7:1].
module oc8051_psw_merge
    import oc8051_wb_pkg::*;
(
    input  logic [7:1] i_psw,
    input  logic       i_upd,
    input  logic [1:0] i_psw_set,
    input  logic       i_md_commit,
    input  logic       i_cy,
    input  logic       i_ac,
    input  logic       i_ov,
    input  logic       i_sfr_wr,
    input  logic [7:1] i_sfr_data,
    output logic [7:1] o_psw
);

    // SFR write forms the base; flag updates then own the bits they touch.
    always_comb begin
        o_psw = i_sfr_wr ? i_sfr_data : i_psw;
        if (i_upd) begin
            case (i_psw_set)
                PSET_CY: begin
                    o_psw[PSW_CY] = i_cy;
                end
                PSET_CAO: begin
                    o_psw[PSW_CY] = i_cy;
                    o_psw[PSW_AC] = i_ac;
                    o_psw[PSW_OV] = i_ov;
                end
                PSET_CA: begin
                    o_psw[PSW_CY] = i_cy;
                    o_psw[PSW_AC] = i_ac;
                end
                default: ;
            endcase
        end
        if (i_md_commit) begin
            o_psw[PSW_CY] = 1'b0;
            o_psw[PSW_OV] = i_ov;
        end
    end

endmodule

// File: rtl/oc8051_alu_wb.sv
// Purpose: commit 8051 ALU results to ACC, B, PSW flags and an internal-RAM write port.
// Latency: 1 edge for plain ops; MULDIV_CYCLES edges after accept for MUL/DIV.
// Backpressure: op_ready low while a MUL/DIV settles or a RAM write awaits ram_wr_ready.
// Ports: op_* upstream handshake + op fields; des* ALU results; psw_wr* SFR write;
//        acc/b_reg/psw architectural state; ram_wr_* valid/ready write port; busy.
module oc8051_alu_wb
    import oc8051_wb_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_code,
    input  logic [1:0] psw_set,
    input  logic [1:0] wr_sel,
    input  logic [7:0] wr_addr,
    input  logic [7:0] des_acc,
    input  logic [7:0] des1,
    input  logic [7:0] des2,
    input  logic       desCy,
    input  logic       desAc,
    input  logic       desOv,
    input  logic       psw_wr,
    input  logic [7:0] psw_wr_data,
    output logic [7:0] acc,
    output logic [7:0] b_reg,
    output logic [7:0] psw,
    output logic       ram_wr_valid,
    output logic [7:0] ram_wr_addr,
    output logic [7:0] ram_wr_data,
    input  logic       ram_wr_ready,
    output logic       busy
);

    wb_state_t  r_state;
    wb_state_t  w_state_nxt;
    logic [3:0] r_cnt;
    logic [7:0] r_acc;
    logic [7:0] r_b;
    logic [7:1] r_psw;
    logic       r_ram_vld;
    logic [7:0] r_ram_addr;
    logic [7:0] r_ram_data;

    logic       w_accept;
    logic       w_is_md;
    logic       w_plain;
    logic       w_md_done;
    logic [7:1] w_psw_nxt;
    logic       w_unused;

    // parity is always derived from ACC, so the written P bit is dropped
    assign w_unused  = psw_wr_data[0];

    assign w_accept  = op_valid && (r_state == ST_IDLE);
    assign w_is_md   = is_muldiv(op_code);
    assign w_plain   = w_accept && !w_is_md;
    assign w_md_done = (r_state == ST_MDWAIT) && (r_cnt == 4'd0);

    oc8051_psw_merge u_psw_merge (
        .i_psw       (r_psw),
        .i_upd       (w_plain),
        .i_psw_set   (psw_set),
        .i_md_commit (w_md_done),
        .i_cy        (desCy),
        .i_ac        (desAc),
        .i_ov        (desOv),
        .i_sfr_wr    (psw_wr),
        .i_sfr_data  (psw_wr_data[7:1]),
        .o_psw       (w_psw_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_md)
                        w_state_nxt = ST_MDWAIT;
                    else if (wr_sel == WR_RAM)
                        w_state_nxt = ST_WBHOLD;
                end
            end
            ST_MDWAIT: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = ST_IDLE;
            end
            ST_WBHOLD: begin
                if (ram_wr_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 4'd0;
            r_acc      <= 8'h00;
            r_b        <= 8'h00;
            r_psw      <= 7'h00;
            r_ram_vld  <= 1'b0;
            r_ram_addr <= 8'h00;
            r_ram_data <= 8'h00;
        end else begin
            r_psw <= w_psw_nxt;

            // MUL/DIV outputs are sampled only once the ALU has settled
            if (w_accept && w_is_md)
                r_cnt <= 4'(MULDIV_CYCLES - 1);
            else if ((r_state == ST_MDWAIT) && (r_cnt != 4'd0))
                r_cnt <= r_cnt - 4'd1;

            if (w_md_done) begin
                r_acc <= des_acc;
                r_b   <= des2;
            end else if (w_plain) begin
                if ((wr_sel == WR_ACC) || (wr_sel == WR_ACCB))
                    r_acc <= des_acc;
                if (wr_sel == WR_ACCB)
                    r_b <= des2;
            end

            if (w_plain && (wr_sel == WR_RAM)) begin
                r_ram_vld  <= 1'b1;
                r_ram_addr <= wr_addr;
                r_ram_data <= des1;
            end else if ((r_state == ST_WBHOLD) && ram_wr_ready) begin
                r_ram_vld <= 1'b0;
            end
        end
    end

    assign op_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign acc          = r_acc;
    assign b_reg        = r_b;
    assign psw          = {r_psw, ^r_acc};
    assign ram_wr_valid = r_ram_vld;
    assign ram_wr_addr  = r_ram_addr;
    assign ram_wr_data  = r_ram_data;

endmodule

// File: doc/oc8051_alu_wb.md
Name: oc8051_alu_wb

Overview:
- Writeback/flag stage directly downstream of the 8051 ALU.
- Captures ALU results (des_acc, des1, des2, desCy/desAc/desOv) and commits them to the architectural ACC and B registers, the PSW flags, and an internal-RAM write port.
- Sequences multi-cycle MUL/DIV by waiting a fixed settle time before committing.
- Applies valid/ready backpressure upstream while a commit is pending.

Parameters:
- MULDIV_CYCLES, 4: cycles from MUL/DIV accept until the ALU mul/div outputs are sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- op_valid  in  1  ALU result present this cycle.
- op_ready  out  1  stage can accept an op; equals (state==IDLE).
- op_code  in  4  ALU op code, same encoding as ALU (NOP 0000 … MUL 0011, DIV 0100 … XCH 1111).
- psw_set  in  2  flag update: 00 none, 01 CY, 10 CY+AC+OV, 11 CY+AC.
- wr_sel  in  2  destination: 00 none, 01 ACC, 10 RAM, 11 ACC+B.
- wr_addr  in  8  RAM write address.
- des_acc  in  8  ALU accumulator result.
- des1  in  8  ALU primary result (RAM data).
- des2  in  8  ALU secondary result (B for MUL/DIV).
- desCy  in  1  ALU carry.
- desAc  in  1  ALU auxiliary carry.
- desOv  in  1  ALU overflow.
- psw_wr  in  1  direct SFR write to PSW.
- psw_wr_data  in  8  SFR write data.
- acc  out  8  accumulator register.
- b_reg  out  8  B register.
- psw  out  8  {CY,AC,F0,RS1,RS0,OV,F1,P}.
- ram_wr_valid  out  1  RAM write request.
- ram_wr_addr  out  8  RAM write address.
- ram_wr_data  out  8  RAM write data.
- ram_wr_ready  in  1  RAM accepts the write.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - acc=0, b_reg=0, psw[7:1]=0, ram_wr_valid=0, ram_wr_addr=0, ram_wr_data=0, counter=0, state=IDLE.
  - op_ready=1 and busy=0 while in reset.
  - Reset mid-operation abandons the op with no partial commit.
- P (psw[0]) is combinational ^acc at all times and is never stored; psw_wr_data[0] is ignored.
- States: IDLE, MDWAIT, WBHOLD.
- Accept occurs when op_valid & op_ready.
- Non-MUL/DIV accept (1-cycle latency), on the same edge:
  - wr_sel 01: acc<=des_acc.
  - wr_sel 11: acc<=des_acc, b_reg<=des2.
  - wr_sel 10 or 11 with a RAM write: ram_wr_valid<=1, ram_wr_addr<=wr_addr, ram_wr_data<=des1; state<=WBHOLD. Only wr_sel 10 issues a RAM write.
  - PSW flags per psw_set.
  - State stays IDLE unless a RAM write was issued.
- WBHOLD:
  - ram_wr_valid/addr/data held stable until ram_wr_ready=1.
  - On that edge ram_wr_valid<=0 and state<=IDLE.
  - op_ready=0 throughout.
- MUL (0011) / DIV (0100) accept:
  - state<=MDWAIT, counter<=MULDIV_CYCLES-1; nothing is committed on the accept edge.
  - Upstream holds op_code and operands stable while busy.
  - MDWAIT decrements each cycle. On the edge where counter==0: acc<=des_acc, b_reg<=des2, CY<=0, OV<=desOv, AC unchanged, state<=IDLE.
  - Total latency is MULDIV_CYCLES edges after accept. The psw_set and wr_sel inputs are ignored for MUL/DIV.
- PSW write priority: when psw_wr coincides with a flag update, the flag update owns the bits it touches and psw_wr_data supplies all other bits [7:1]. psw_wr alone writes [7:1] in any state.
- op_valid while op_ready=0 is ignored; no queueing.
- Counter width is 4 bits. With MULDIV_CYCLES=1 the commit occurs on the edge after accept.

Decomposition:
- Shared package oc8051_wb_pkg holds:
  - ALU op-code constants (shared with the ALU's define set).
  - PSW bit indices (CY=7, AC=6, OV=2, P=0).
  - psw_set encodings, wr_sel encodings, and the state enum.
- One natural sub-module, oc8051_psw_merge: combinational merge of the current PSW, psw_set, flags, and the SFR write into next-PSW bits [7:1].
- The counter and FSM stay in the top module.

Test Plan:
- ADD: des_acc=8'h3C, desCy=1, desAc=0, desOv=1, psw_set=10, wr_sel=01 -> next edge acc=8'h3C, psw=8'h84 (P=0), op_ready stays 1.
- MUL with MULDIV_CYCLES=4: des_acc=8'h90, des2=8'h01, desOv=1 held -> op_ready=0 for 4 cycles; after the 4th edge acc=8'h90, b_reg=8'h01, CY=0, OV=1.
- RAM write: wr_sel=10, wr_addr=8'h30, des1=8'h5A, ram_wr_ready low 3 cycles -> valid/addr/data stable and a second op_valid ignored; valid drops the cycle after ready=1.
- Simultaneous psw_wr (data 8'h18) and psw_set=01 with desCy=1, acc=0 -> psw=8'h98.
- Reset asserted 2 cycles into MDWAIT -> immediately acc=0, psw=0, op_ready=1, busy=0; no commit after release.
- NOP with wr_sel=01, des_acc=8'h01, psw_set=00 -> acc=8'h01, P=1, CY/AC/OV unchanged.
